// File: rtl/ex_forward_ctrl.sv
// Operand-forward select and load-use stall for EX; fwd_a/fwd_b/ex_valid_o registered (1 cycle after ID), stall combinational.
// No handshake: stall holds PC/IF/ID for exactly one cycle per load-use hazard while a bubble enters EX.
module ex_forward_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             ex_valid_o
);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } ex_stage_t;

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             regwrite;
    } mem_stage_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;

    logic ex_wr, mem_wr;
    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic load_use;
    logic take;

    always_comb begin
        ex_wr      = ex_q.vld  & ex_q.regwrite;
        mem_wr     = mem_q.vld & mem_q.regwrite;
        ex_hit_rs  = ex_wr  & (ex_q.rd  == id_rs) & (id_rs != '0);
        ex_hit_rt  = ex_wr  & (ex_q.rd  == id_rt) & (id_rt != '0) & id_uses_rt;
        mem_hit_rs = mem_wr & (mem_q.rd == id_rs) & (id_rs != '0);
        mem_hit_rt = mem_wr & (mem_q.rd == id_rt) & (id_rt != '0) & id_uses_rt;

        // A load in EX has no data until MEM completes, so a dependent decode must wait one cycle.
        load_use = ex_q.vld & ex_q.memread & (ex_q.rd != '0) &
                   ((ex_q.rd == id_rs) | (id_uses_rt & (ex_q.rd == id_rt)));
        stall    = id_valid & ~flush & load_use;
        take     = id_valid & ~flush & ~stall;
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        mem_d   = '{vld: ex_q.vld, rd: ex_q.rd, regwrite: ex_q.regwrite};

        if (take) begin
            ex_d = '{vld: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

            // Nearest producer wins: the EX producer is younger than the MEM one.
            if (ex_hit_rs)       fwd_a_d = SEL_MEM;
            else if (mem_hit_rs) fwd_a_d = SEL_WB;

            if (ex_hit_rt)       fwd_b_d = SEL_MEM;
            else if (mem_hit_rt) fwd_b_d = SEL_WB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;
    assign ex_valid_o = ex_q.vld;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Directed bench for ex_forward_ctrl: per-cycle compare against a pipeline-history model plus literal pins.
module tb_ex_forward_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_uses_rt, id_regwrite, id_memread, flush;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
    logic       ex_valid_o;

    int checks = 0;
    int errors = 0;
    logic last_stall;

    ex_forward_ctrl #(.REG_W(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_memread (id_memread),
        .flush      (flush),
        .stall      (stall),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .ex_valid_o (ex_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: hist[0] is the instruction issued last cycle (now in EX), hist[1] the one before (now in MEM).
    typedef struct {
        bit       valid;
        bit [4:0] rd;
        bit       regwrite;
        bit       memread;
    } prod_t;

    prod_t    hist [2];
    bit [1:0] exp_a, exp_b;
    bit       exp_exv;

    function automatic bit [1:0] model_sel(input bit [4:0] src);
        if (src == 0) return 2'd0;
        for (int d = 0; d < 2; d++) begin
            if (hist[d].valid && hist[d].regwrite && hist[d].rd == src)
                return (d == 0) ? 2'd2 : 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic bit model_stall();
        bit dep;
        if (!id_valid || flush) return 1'b0;
        if (!hist[0].valid || !hist[0].memread || hist[0].rd == 0) return 1'b0;
        dep = (hist[0].rd == id_rs) || (id_uses_rt && hist[0].rd == id_rt);
        return dep;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) hist[i] <= '{default: 0};
            exp_a   <= 2'd0;
            exp_b   <= 2'd0;
            exp_exv <= 1'b0;
        end else begin
            bit issue;
            issue = id_valid && !flush && !model_stall();
            hist[1] <= hist[0];
            if (issue) begin
                hist[0] <= '{valid: 1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
                exp_a   <= model_sel(id_rs);
                exp_b   <= id_uses_rt ? model_sel(id_rt) : 2'd0;
            end else begin
                hist[0] <= '{default: 0};
                exp_a   <= 2'd0;
                exp_b   <= 2'd0;
            end
            exp_exv <= issue;
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_stall", {1'b0, stall}, {1'b0, model_stall()});
            chk("model_fwd_a", fwd_a, exp_a);
            chk("model_fwd_b", fwd_b, exp_b);
            chk("model_exv",   {1'b0, ex_valid_o}, {1'b0, exp_exv});
        end
    end

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rt  = ut;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        #2;
        last_stall = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        issue(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        last_stall = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        #3;
        chk("reset_stall", {1'b0, stall}, 2'd0);
        chk("reset_fwd_a", fwd_a, 2'd0);
        chk("reset_fwd_b", fwd_b, 2'd0);
        chk("reset_exv",   {1'b0, ex_valid_o}, 2'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // EX->EX: add r3,r1,r2 ; sub r4,r3,r3
        issue(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        issue(1, 5'd3, 5'd3, 1, 5'd4, 1, 0, 0);
        chk("exex_stall", {1'b0, last_stall}, 2'd0);
        chk("exex_fwd_a", fwd_a, 2'b10);
        chk("exex_fwd_b", fwd_b, 2'b10);
        nop(); nop();

        // Priority: add r3 ; add r3 ; and r6,r3,r1
        issue(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        issue(1, 5'd1, 5'd2, 1, 5'd3, 1, 0, 0);
        issue(1, 5'd3, 5'd1, 1, 5'd6, 1, 0, 0);
        chk("prio_fwd_a", fwd_a, 2'b10);
        chk("prio_fwd_b", fwd_b, 2'b00);
        nop(); nop();

        // MEM->EX on operand B: add r10 ; nop ; use r10 as rt
        issue(1, 5'd1, 5'd2, 1, 5'd10, 1, 0, 0);
        nop();
        issue(1, 5'd11, 5'd10, 1, 5'd12, 1, 0, 0);
        chk("memfwd_fwd_a", fwd_a, 2'b00);
        chk("memfwd_fwd_b", fwd_b, 2'b01);
        nop(); nop();

        // Load-use: lw r7 ; add r8,r7,r2 (stalls once, then retried)
        issue(1, 5'd1, 5'd0, 0, 5'd7, 1, 1, 0);
        issue(1, 5'd7, 5'd2, 1, 5'd8, 1, 0, 0);
        chk("lu_stall",  {1'b0, last_stall}, 2'd1);
        chk("lu_bubble", {1'b0, ex_valid_o}, 2'd0);
        issue(1, 5'd7, 5'd2, 1, 5'd8, 1, 0, 0);
        chk("lu_retry_stall", {1'b0, last_stall}, 2'd0);
        chk("lu_retry_exv",   {1'b0, ex_valid_o}, 2'd1);
        chk("lu_retry_fwd_a", fwd_a, 2'b01);
        chk("lu_retry_fwd_b", fwd_b, 2'b00);
        nop(); nop();

        // Zero register / uses_rt
        issue(1, 5'd1, 5'd2, 1, 5'd0, 1, 0, 0);
        issue(1, 5'd0, 5'd0, 0, 5'd9, 1, 0, 0);
        chk("zero_fwd_a", fwd_a, 2'b00);
        chk("zero_fwd_b", fwd_b, 2'b00);
        issue(1, 5'd1, 5'd0, 0, 5'd0, 1, 1, 0);
        issue(1, 5'd0, 5'd0, 1, 5'd9, 1, 0, 0);
        chk("zero_lu_stall", {1'b0, last_stall}, 2'd0);
        nop(); nop();

        // Flush beats stall
        issue(1, 5'd1, 5'd0, 0, 5'd7, 1, 1, 0);
        issue(1, 5'd7, 5'd2, 1, 5'd8, 1, 0, 1);
        chk("flush_stall", {1'b0, last_stall}, 2'd0);
        chk("flush_exv",   {1'b0, ex_valid_o}, 2'd0);
        chk("flush_fwd_a", fwd_a, 2'b00);
        issue(1, 5'd7, 5'd2, 1, 5'd8, 1, 0, 0);
        chk("postflush_stall", {1'b0, last_stall}, 2'd0);
        chk("postflush_fwd_a", fwd_a, 2'b01);
        nop(); nop();

        // Reset asserted mid-stall
        issue(1, 5'd1, 5'd0, 0, 5'd5, 1, 1, 0);
        id_valid = 1; id_rs = 5'd5; id_rt = 5'd5; id_uses_rt = 1;
        id_rd = 5'd6; id_regwrite = 1; id_memread = 0; flush = 0;
        #1;
        chk("rst_pre_stall", {1'b0, stall}, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {1'b0, stall}, 2'd0);
        chk("rst_mid_fwd_a", fwd_a, 2'd0);
        chk("rst_mid_fwd_b", fwd_b, 2'd0);
        chk("rst_mid_exv",   {1'b0, ex_valid_o}, 2'd0);
        id_valid = 0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1, 5'd5, 5'd5, 1, 5'd6, 1, 0, 0);
        chk("postrst_stall", {1'b0, last_stall}, 2'd0);
        chk("postrst_fwd_a", fwd_a, 2'b00);
        chk("postrst_fwd_b", fwd_b, 2'b00);
        nop(); nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_forward_ctrl.md
# ex_forward_ctrl

Operand-forwarding and load-use hazard controller for the 5-stage pipeline. Tracks destination-register information of in-flight instructions through EX, MEM and WB, compares it against the source registers of the instruction leaving ID, and produces the registered 2-bit select pair that drives the two 32-bit 3-to-1 ALU operand muxes in EX. Also raises the load-use stall that freezes PC/IF/ID and inserts a bubble into EX.

## Interface
- REG_W, 5, register-address width (32 architectural registers; register 0 is hard-wired zero)
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID holds a real instruction
- id_rs  input  REG_W  source register A of ID instruction
- id_rt  input  REG_W  source register B of ID instruction
- id_uses_rt  input  1  ID instruction reads id_rt as an ALU operand
- id_rd  input  REG_W  destination register of ID instruction
- id_regwrite  input  1  ID instruction writes id_rd
- id_memread  input  1  ID instruction is a load
- flush  input  1  squash ID instruction (taken branch/jump)
- stall  output  1  load-use hazard; hold PC and IF/ID, bubble into EX
- fwd_a  output  2  operand-A select for EX mux: 00 reg-file, 01 WB result, 10 MEM result
- fwd_b  output  2  operand-B select, same encoding
- ex_valid_o  output  1  EX holds a real (non-bubble) instruction; debug/verification visibility

## Operation
- Internal tracking registers: EX {valid, rd, regwrite, memread}; MEM {valid, rd, regwrite}. Each cycle EX shifts to MEM, MEM retires (WB producers are resolved by the write-before-read register file and need no tracking).
- Producer in EX at decode time will be in MEM when consumer is in EX -> select 10. Producer in MEM at decode time will be in WB -> select 01.
- Match rule per source s: producer valid & regwrite & rd == s & s != 0.
- Priority: EX-stage producer (10) over MEM-stage producer (01) over register file (00). Code 11 is never driven.
- fwd_b only forwards when id_uses_rt = 1; otherwise 00.
- Load-use: stall = id_valid & ~flush & EX.valid & EX.memread & EX.rd != 0 & (EX.rd == id_rs | (id_uses_rt & EX.rd == id_rt)).
- Next EX state: if flush, stall or ~id_valid -> bubble (valid 0, regwrite 0, memread 0, fwd 00). Otherwise capture id_rd/id_regwrite/id_memread with valid 1 and register computed fwd_a/fwd_b.
- During stall the ID instruction is re-presented next cycle; after the bubble the load is in MEM, so the retried decode selects 01 (WB result) for the dependent operand.
- flush and stall together: flush wins; stall = 0, bubble inserted.

## Timing
- Reset (rst_n low, asynchronous): all valid/regwrite/memread bits 0, rd fields 0, fwd_a = fwd_b = 00, ex_valid_o = 0; stall = 0 since EX.valid = 0.
- fwd_a/fwd_b/ex_valid_o: registered, valid for the instruction in EX, one cycle after it was presented in ID.
- stall: combinational from ID inputs and EX state, same cycle; exactly one stall cycle per load-use hazard.
- Reset asserted mid-stall: stall drops immediately; tracked producers are discarded, no forwarding after release.
- Throughput: one instruction per cycle absent hazards.

## Test plan
- Reset: assert rst_n=0 mid-run with EX holding a load to r5 and ID reading r5 -> stall=0, fwd_a=fwd_b=00, ex_valid_o=0 immediately, before next edge.
- EX->EX forward: add r3 then sub r4,r3,r3 back-to-back -> cycle after sub decodes, fwd_a=10, fwd_b=10, stall never asserted.
- Priority: add r3; add r3; and r6,r3,r1 -> for and, fwd_a=10 (nearest), fwd_b=00.
- Load-use: lw r7 then add r8,r7,r2 -> stall=1 for exactly one cycle, EX bubble (ex_valid_o=0), then add enters EX with fwd_a=01.
- Zero register and uses_rt: add r0 then or r9,r0,r0 with id_uses_rt=0 -> fwd_a=00, fwd_b=00; lw r0 then use r0 -> no stall.
- Flush: lw r7 in EX, ID reads r7 with flush=1 -> stall=0, next cycle ex_valid_o=0, fwd 00; following instruction reading r7 gets 01 with no stall.
